// File: rtl/adc_serial_emulator.sv
// Emulates a dual-channel serial ADC: on each host frame, shifts out
// {LEAD_ZEROS zeros, sample} MSB first on the ADC_clk falling edges.
module adc_serial_emulator #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned LEAD_ZEROS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ADC_clk,
    input  logic              chip_select,
    input  logic [DATA_W-1:0] sample1,
    input  logic [DATA_W-1:0] sample2,
    output logic              Data1,
    output logic              Data2,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_count
);

    localparam int unsigned FRAME_LEN = LEAD_ZEROS + DATA_W;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e               state_q, state_d;
    logic [1:0]           adc_sync_q, cs_sync_q;
    logic                 adc_prev_q, cs_prev_q;
    logic [FRAME_LEN-1:0] sreg1_q, sreg1_d, sreg2_q, sreg2_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           count_q, count_d;
    logic                 done_q, done_d, err_q, err_d;

    logic adc_fall, cs_fall, cs_rise;

    // Strobes come from the second synchronizer stage versus its delayed copy,
    // giving three clk cycles from pin edge to state change.
    assign adc_fall = adc_prev_q & ~adc_sync_q[1];
    assign cs_fall  = cs_prev_q & ~cs_sync_q[1];
    assign cs_rise  = ~cs_prev_q & cs_sync_q[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            adc_sync_q <= '0;
            cs_sync_q  <= '0;
            adc_prev_q <= 1'b0;
            cs_prev_q  <= 1'b0;
            state_q    <= StIdle;
            sreg1_q    <= '0;
            sreg2_q    <= '0;
            cnt_q      <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            adc_sync_q <= {adc_sync_q[0], ADC_clk};
            cs_sync_q  <= {cs_sync_q[0], chip_select};
            adc_prev_q <= adc_sync_q[1];
            cs_prev_q  <= cs_sync_q[1];
            state_q    <= state_d;
            sreg1_q    <= sreg1_d;
            sreg2_q    <= sreg2_d;
            cnt_q      <= cnt_d;
            count_q    <= count_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg1_d = sreg1_q;
        sreg2_d = sreg2_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    sreg1_d = {{LEAD_ZEROS{1'b0}}, sample1};
                    sreg2_d = {{LEAD_ZEROS{1'b0}}, sample2};
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                // chip_select release takes priority over a coincident shift.
                if (cs_rise) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (adc_fall) begin
                    sreg1_d = {sreg1_q[FRAME_LEN-2:0], 1'b0};
                    sreg2_d = {sreg2_q[FRAME_LEN-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        count_d = count_q + 8'd1;
                    end
                end
            end
            StDone: begin
                if (cs_rise) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q == StShift);
    assign Data1       = busy & sreg1_q[FRAME_LEN-1];
    assign Data2       = busy & sreg2_q[FRAME_LEN-1];
    assign frame_done  = done_q;
    assign frame_err   = err_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_adc_serial_emulator.sv
// Directed bench for adc_serial_emulator: table of frame scenarios plus
// hand-written latency, collision, reset and wrap sequences.
`timescale 1ns/1ps
module tb_adc_serial_emulator;

    localparam int HALF = 8;  // ADC_clk half period in clk cycles (16x ratio)

    logic        clk = 1'b0;
    logic        reset;
    logic        ADC_clk;
    logic        chip_select;
    logic [11:0] sample1, sample2;
    logic        Data1, Data2, busy, frame_done, frame_err;
    logic [7:0]  frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int err_seen  = 0;

    typedef struct {
        logic [11:0] s1;
        logic [11:0] s2;
        int          nfalls;
        int          chg_at;   // after this many falls, sample1 <= s1_new (0: never)
        logic [11:0] s1_new;
        logic [15:0] exp_d1;
        logic [15:0] exp_d2;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[8];

    adc_serial_emulator #(.DATA_W(12), .LEAD_ZEROS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .ADC_clk     (ADC_clk),
        .chip_select (chip_select),
        .sample1     (sample1),
        .sample2     (sample2),
        .Data1       (Data1),
        .Data2       (Data2),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_seen++;
        if (frame_err) err_seen++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic adc_fall_rise();
        ADC_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ADC_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Starts a frame and issues nfalls ADC_clk falls, capturing the data bit
    // presented before each fall. Leaves chip_select low and returns at a negedge.
    task automatic run_frame(input vec_t v, output logic [15:0] c1, output logic [15:0] c2);
        sample1 = v.s1;
        sample2 = v.s2;
        c1 = '0;
        c2 = '0;
        @(negedge clk);
        chip_select = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < v.nfalls; k++) begin
            if (k < 16) begin
                c1[15-k] = Data1;
                c2[15-k] = Data2;
            end
            adc_fall_rise();
            if (v.chg_at == k + 1) sample1 = v.s1_new;
        end
    endtask

    task automatic end_frame();
        chip_select = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    logic [15:0] c1, c2, m;
    logic [7:0]  cnt_model;
    int          d0, e0;

    initial begin
        vecs[0] = '{12'hA5C, 12'h3F0, 16, 0, 12'h000, 16'h0A5C, 16'h03F0, 1, 0};
        vecs[1] = '{12'hA5C, 12'h3F0,  9, 0, 12'h000, 16'h0A5C, 16'h03F0, 0, 1};
        vecs[2] = '{12'hA5C, 12'h3F0, 16, 0, 12'h000, 16'h0A5C, 16'h03F0, 1, 0};
        vecs[3] = '{12'hFFF, 12'h123, 16, 6, 12'h000, 16'h0FFF, 16'h0123, 1, 0};
        vecs[4] = '{12'h800, 12'h001, 20, 0, 12'h000, 16'h0800, 16'h0001, 1, 0};
        vecs[5] = '{12'h000, 12'hFFF, 16, 0, 12'h000, 16'h0000, 16'h0FFF, 1, 0};
        vecs[6] = '{12'h555, 12'hAAA, 15, 0, 12'h000, 16'h0555, 16'h0AAA, 0, 1};
        vecs[7] = '{12'h123, 12'h456,  0, 0, 12'h000, 16'h0000, 16'h0000, 0, 1};

        reset = 1'b0;
        ADC_clk = 1'b1;
        chip_select = 1'b1;
        sample1 = '0;
        sample2 = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {27'd0, Data1, Data2, busy, frame_done, frame_err}, 32'd0);
        check("reset_count", {24'd0, frame_count}, 32'd0);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        cnt_model = 8'd0;

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            d0 = done_seen;
            e0 = err_seen;
            run_frame(vecs[i], c1, c2);
            if (vecs[i].nfalls >= 16) begin
                check($sformatf("row%0d_data_in_done", i), {30'd0, Data1, Data2}, 32'd0);
                check($sformatf("row%0d_busy_in_done", i), {31'd0, busy}, 32'd0);
            end
            end_frame();
            m = 16'hFFFF;
            m = (vecs[i].nfalls >= 16) ? m : ~(m >> vecs[i].nfalls);
            cnt_model = cnt_model + 8'(vecs[i].exp_done);
            check($sformatf("row%0d_d1", i), {16'd0, c1 & m}, {16'd0, vecs[i].exp_d1 & m});
            check($sformatf("row%0d_d2", i), {16'd0, c2 & m}, {16'd0, vecs[i].exp_d2 & m});
            check($sformatf("row%0d_done", i), done_seen - d0, vecs[i].exp_done);
            check($sformatf("row%0d_err", i), err_seen - e0, vecs[i].exp_err);
            check($sformatf("row%0d_count", i), {24'd0, frame_count}, {24'd0, cnt_model});
            check($sformatf("row%0d_idle", i), {29'd0, busy, Data1, Data2}, 32'd0);
        end

        // Latency: busy rises exactly 3 clk edges after chip_select falls;
        // frame_err pulses one cycle, 3 edges after chip_select rises.
        @(negedge clk);
        chip_select = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("lat_busy_early", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("lat_busy", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        chip_select = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lat_err_early", {30'd0, busy, frame_err}, 32'd2);
        @(negedge clk);
        check("lat_err", {30'd0, busy, frame_err}, 32'd1);
        @(negedge clk);
        check("lat_err_width", {31'd0, frame_err}, 32'd0);
        repeat (4) @(negedge clk);

        // chip_select rise coinciding with an ADC_clk fall: abort wins
        d0 = done_seen;
        e0 = err_seen;
        vecs[0].nfalls = 15;
        run_frame(vecs[0], c1, c2);
        ADC_clk = 1'b0;
        chip_select = 1'b1;
        repeat (3) @(negedge clk);
        check("coll_err_pulse", {30'd0, frame_err, frame_done}, 32'd2);
        repeat (6) @(negedge clk);
        ADC_clk = 1'b1;
        repeat (6) @(negedge clk);
        check("coll_done", done_seen - d0, 0);
        check("coll_err", err_seen - e0, 1);
        check("coll_count", {24'd0, frame_count}, {24'd0, cnt_model});
        vecs[0].nfalls = 16;

        // Reset mid-frame after the 5th fall
        d0 = done_seen;
        e0 = err_seen;
        vecs[3].nfalls = 5;
        vecs[3].chg_at = 0;
        run_frame(vecs[3], c1, c2);
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_outputs", {27'd0, Data1, Data2, busy, frame_done, frame_err}, 32'd0);
        check("rst_count", {24'd0, frame_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) adc_fall_rise();
        check("rst_no_restart", {31'd0, busy}, 32'd0);
        end_frame();
        check("rst_no_pulses", (done_seen - d0) + (err_seen - e0), 0);
        cnt_model = 8'd0;
        run_frame(vecs[0], c1, c2);
        end_frame();
        check("rst_next_d1", {16'd0, c1}, 32'h0A5C);
        check("rst_next_d2", {16'd0, c2}, 32'h03F0);
        check("rst_next_count", {24'd0, frame_count}, 32'd1);

        // 256 back-to-back frames wrap frame_count
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        d0 = done_seen;
        e0 = err_seen;
        for (int i = 0; i < 256; i++) begin
            vecs[5].s1 = 12'(i);
            run_frame(vecs[5], c1, c2);
            end_frame();
            if (i == 254) check("wrap_255", {24'd0, frame_count}, 32'd255);
        end
        check("wrap_count", {24'd0, frame_count}, 32'd0);
        check("wrap_done", done_seen - d0, 256);
        check("wrap_err", err_seen - e0, 0);
        check("wrap_last_d1", {16'd0, c1}, 32'h00FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
